tl_sram_bridge: RTL and testbench

TL_SRAM_BRIDGE -- requirements
Module: tl_sram_bridge

---
 rtl/tl_sram_bridge.sv | 147 ++++++++++++++
 tb/tb_tl_sram_bridge.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_sram_bridge.sv
// TileLink-UL slave endpoint in front of a single-port 64-bit SRAM.
// Holds one transaction at a time: a request is accepted only in IDLE,
// the SRAM is strobed combinationally in the acceptance cycle, and the
// response is kept in a holding register until the D-channel handshake.
module tl_sram_bridge #(
  parameter int SOURCE_WIDTH  = 2,
  parameter int TL_ADDR_WIDTH = 64,
  parameter int SRAM_AW       = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     a_valid_i,
  output logic                     a_ready_o,
  input  logic [2:0]               a_opcode_i,
  input  logic [2:0]               a_size_i,
  input  logic [SOURCE_WIDTH-1:0]  a_source_i,
  input  logic [TL_ADDR_WIDTH-1:0] a_address_i,
  input  logic [7:0]               a_mask_i,
  input  logic [63:0]              a_data_i,
  output logic                     d_valid_o,
  input  logic                     d_ready_i,
  output logic [2:0]               d_opcode_o,
  output logic [2:0]               d_size_o,
  output logic [SOURCE_WIDTH-1:0]  d_source_o,
  output logic [63:0]              d_data_o,
  output logic                     d_denied_o,
  output logic                     sram_req_o,
  output logic                     sram_we_o,
  output logic [SRAM_AW-1:0]       sram_addr_o,
  output logic [7:0]               sram_be_o,
  output logic [63:0]              sram_wdata_o,
  input  logic [63:0]              sram_rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RDWAIT = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              d_opcode_q, d_opcode_d;
  logic [2:0]              d_size_q, d_size_d;
  logic [SOURCE_WIDTH-1:0] d_source_q, d_source_d;
  logic [63:0]             d_data_q, d_data_d;
  logic                    d_denied_q, d_denied_d;

  logic       accept;
  logic       is_get;
  logic       opcode_ok;
  logic       denied;
  logic [2:0] align_mask;
  logic       unused_addr;

  // Address bits above the SRAM word range are intentionally ignored.
  assign unused_addr = ^a_address_i[TL_ADDR_WIDTH-1:SRAM_AW+3];

  assign a_ready_o = (state_q == IDLE);
  assign accept    = a_valid_i & a_ready_o;
  assign is_get    = (a_opcode_i == 3'd4);
  assign opcode_ok = (a_opcode_i == 3'd0) | (a_opcode_i == 3'd1) | is_get;

  // Low address bits that must be zero for a naturally aligned transfer.
  always_comb begin
    align_mask = 3'b000;
    case (a_size_i)
      3'd0:    align_mask = 3'b000;
      3'd1:    align_mask = 3'b001;
      3'd2:    align_mask = 3'b011;
      3'd3:    align_mask = 3'b111;
      default: align_mask = 3'b000;
    endcase
  end

  assign denied = ~opcode_ok | (a_size_i > 3'd3) |
                  ((a_address_i[2:0] & align_mask) != 3'b000);

  // SRAM strobe fires in the acceptance cycle only, and never for a denied request.
  assign sram_req_o   = accept & ~denied;
  assign sram_we_o    = ~is_get;
  assign sram_addr_o  = a_address_i[SRAM_AW+2:3];
  assign sram_be_o    = is_get ? 8'hFF : a_mask_i;
  assign sram_wdata_o = a_data_i;

  assign d_valid_o  = (state_q == RESP);
  assign d_opcode_o = d_opcode_q;
  assign d_size_o   = d_size_q;
  assign d_source_o = d_source_q;
  assign d_data_o   = d_data_q;
  assign d_denied_o = d_denied_q;

  // Next-state and response-holding-register update.
  always_comb begin
    state_d    = state_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_data_d   = d_data_q;
    d_denied_d = d_denied_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          d_opcode_d = is_get ? 3'd1 : 3'd0;
          d_size_d   = a_size_i;
          d_source_d = a_source_i;
          d_denied_d = denied;
          d_data_d   = 64'd0;
          state_d    = (is_get && !denied) ? RDWAIT : RESP;
        end else begin
          state_d = IDLE;
        end
      end
      RDWAIT: begin
        d_data_d = sram_rdata_i;
        state_d  = RESP;
      end
      RESP: begin
        if (d_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset discards any in-flight transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      d_opcode_q <= 3'd0;
      d_size_q   <= 3'd0;
      d_source_q <= '0;
      d_data_q   <= 64'd0;
      d_denied_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;
      d_source_q <= d_source_d;
      d_data_q   <= d_data_d;
      d_denied_q <= d_denied_d;
    end
  end

endmodule

// File: tb/tb_tl_sram_bridge.sv
// Bench for tl_sram_bridge: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_tl_sram_bridge;

  logic        clk;
  logic        rst_ni;
  logic        a_valid_i;
  logic        a_ready_o;
  logic [2:0]  a_opcode_i;
  logic [2:0]  a_size_i;
  logic [1:0]  a_source_i;
  logic [63:0] a_address_i;
  logic [7:0]  a_mask_i;
  logic [63:0] a_data_i;
  logic        d_valid_o;
  logic        d_ready_i;
  logic [2:0]  d_opcode_o;
  logic [2:0]  d_size_o;
  logic [1:0]  d_source_o;
  logic [63:0] d_data_o;
  logic        d_denied_o;
  logic        sram_req_o;
  logic        sram_we_o;
  logic [15:0] sram_addr_o;
  logic [7:0]  sram_be_o;
  logic [63:0] sram_wdata_o;
  logic [63:0] sram_rdata_i;

  int n_tests = 0;
  int n_fail  = 0;

  tl_sram_bridge dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_opcode_i(a_opcode_i),
    .a_size_i(a_size_i), .a_source_i(a_source_i), .a_address_i(a_address_i),
    .a_mask_i(a_mask_i), .a_data_i(a_data_i),
    .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_opcode_o(d_opcode_o),
    .d_size_o(d_size_o), .d_source_o(d_source_o), .d_data_o(d_data_o),
    .d_denied_o(d_denied_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_be_o(sram_be_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Simple SRAM: 16 words, write with byte enables, read data one cycle later.
  logic [63:0] mem_s [0:15];
  always @(posedge clk) begin
    if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 8; b++)
          if (sram_be_o[b]) mem_s[sram_addr_o[3:0]][8*b +: 8] = sram_wdata_o[8*b +: 8];
      end else begin
        sram_rdata_i <= mem_s[sram_addr_o[3:0]];
      end
    end
  end

  // Reference model: one outstanding transaction, response visible after a latency delay.
  logic [63:0] mem_m [0:15];
  bit          m_pend = 1'b0;
  int          m_wait = 0;
  logic [2:0]  m_op, m_size;
  logic [1:0]  m_src;
  logic [63:0] m_data;
  bit          m_den;
  bit          e_ready, e_dvalid, e_acc, e_legal, e_get;
  int          e_word;

  // Every cycle: predict outputs from the model, compare, then advance the model.
  always @(negedge clk) begin
    if (!rst_ni) begin
      chk("rst_dvalid", d_valid_o, 0);
      chk("rst_aready", a_ready_o, 1);
      chk("rst_req", sram_req_o, 0);
      chk("rst_dfields", {d_opcode_o, d_size_o, d_source_o, d_denied_o}, 0);
      chk("rst_ddata", d_data_o, 0);
      m_pend = 1'b0;
    end else begin
      e_ready  = !m_pend;
      e_dvalid = m_pend && (m_wait == 0);
      e_acc    = a_valid_i && e_ready;
      e_get    = (a_opcode_i == 3'd4);
      e_legal  = (a_opcode_i == 3'd0 || a_opcode_i == 3'd1 || e_get) && (a_size_i <= 3'd3)
                 && ((a_address_i % (64'd1 << a_size_i)) == 64'd0);
      e_word   = int'((a_address_i >> 3) & 64'hFFFF);
      chk("m_aready", a_ready_o, e_ready);
      chk("m_dvalid", d_valid_o, e_dvalid);
      chk("m_req", sram_req_o, e_acc && e_legal);
      if (e_acc && e_legal) begin
        chk("m_we", sram_we_o, !e_get);
        chk("m_addr", sram_addr_o, e_word);
        chk("m_be", sram_be_o, e_get ? 8'hFF : a_mask_i);
        if (!e_get) chk("m_wdata", sram_wdata_o, a_data_i);
      end
      if (e_dvalid) begin
        chk("m_dop", d_opcode_o, m_op);
        chk("m_dsize", d_size_o, m_size);
        chk("m_dsrc", d_source_o, m_src);
        chk("m_ddata", d_data_o, m_data);
        chk("m_dden", d_denied_o, m_den);
      end
      if (e_dvalid && d_ready_i) m_pend = 1'b0;
      else if (m_pend && m_wait > 0) m_wait--;
      if (e_acc) begin
        m_pend = 1'b1;
        m_wait = (e_legal && e_get) ? 1 : 0;
        m_op   = e_get ? 3'd1 : 3'd0;
        m_size = a_size_i;
        m_src  = a_source_i;
        m_den  = !e_legal;
        m_data = (e_legal && e_get) ? mem_m[e_word] : 64'd0;
        if (e_legal && !e_get)
          for (int b = 0; b < 8; b++)
            if (a_mask_i[b]) mem_m[e_word][8*b +: 8] = a_data_i[8*b +: 8];
      end
    end
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                     input logic [63:0] ad, input logic [7:0] mk, input logic [63:0] dt);
    a_valid_i = 1'b1; a_opcode_i = op; a_size_i = sz; a_source_i = src;
    a_address_i = ad; a_mask_i = mk; a_data_i = dt;
  endtask

  task automatic rand_req;
    logic [2:0]  op, sz, lo;
    logic [63:0] ad;
    int          r;
    r  = $urandom_range(0, 9);
    op = (r < 3) ? 3'd0 : (r < 5) ? 3'd1 : (r < 9) ? 3'd4 : 3'($urandom_range(0, 7));
    sz = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
    ad = 64'($urandom_range(0, 15)) << 3;
    if ($urandom_range(0, 3) == 0) begin
      lo = 3'($urandom_range(0, 7));
      ad[2:0] = lo;
    end
    ad[40] = 1'($urandom_range(0, 1));
    req(op, sz, 2'($urandom_range(0, 3)), ad, 8'($urandom_range(0, 255)), {$urandom, $urandom});
  endtask

  localparam logic [63:0] PAT = 64'hDEADBEEF_CAFEF00D;
  bit acc;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_m[i] = {$urandom, $urandom};
      mem_s[i] = mem_m[i];
    end
    sram_rdata_i = 64'd0;
    rst_ni = 1'b0; d_ready_i = 1'b1;
    req(3'd0, 3'd0, 2'd0, 64'd0, 8'd0, 64'd0);
    a_valid_i = 1'b0;
    repeat (2) nxt;
    rst_ni = 1'b1;

    // Put to 0x10
    req(3'd0, 3'd3, 2'd2, 64'h10, 8'hFF, PAT);
    @(negedge clk);
    chk("put_req", sram_req_o, 1); chk("put_we", sram_we_o, 1); chk("put_addr", sram_addr_o, 2);
    nxt; a_valid_i = 1'b0;
    @(negedge clk);
    chk("put_dvalid", d_valid_o, 1); chk("put_dop", d_opcode_o, 0);
    chk("put_dsrc", d_source_o, 2); chk("put_dden", d_denied_o, 0);
    nxt;

    // Get from 0x10
    req(3'd4, 3'd3, 2'd1, 64'h10, 8'hFF, 64'd0);
    @(negedge clk);
    chk("get_req", sram_req_o, 1); chk("get_we", sram_we_o, 0); chk("get_be", sram_be_o, 8'hFF);
    nxt; a_valid_i = 1'b0;
    @(negedge clk); chk("get_dvalid_n1", d_valid_o, 0);
    nxt;
    @(negedge clk);
    chk("get_dvalid", d_valid_o, 1); chk("get_dop", d_opcode_o, 1); chk("get_data", d_data_o, PAT);
    nxt;

    // Backpressure: 5 stalled cycles, a Get waiting upstream
    d_ready_i = 1'b0;
    req(3'd0, 3'd3, 2'd3, 64'h18, 8'h0F, 64'h11223344_55667788);
    @(negedge clk); chk("bp_req", sram_req_o, 1);
    nxt;
    req(3'd4, 3'd3, 2'd0, 64'h18, 8'hFF, 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_dvalid", d_valid_o, 1); chk("bp_dsrc", d_source_o, 3); chk("bp_dop", d_opcode_o, 0);
      chk("bp_aready", a_ready_o, 0); chk("bp_noreq", sram_req_o, 0);
      nxt;
    end
    d_ready_i = 1'b1;
    @(negedge clk); chk("bp_hs_dvalid", d_valid_o, 1); chk("bp_hs_aready", a_ready_o, 0);
    nxt;
    @(negedge clk);
    chk("bp_idle_aready", a_ready_o, 1); chk("bp_idle_dvalid", d_valid_o, 0); chk("bp_req2", sram_req_o, 1);
    nxt; a_valid_i = 1'b0;
    nxt;
    @(negedge clk);
    chk("bp_get_dvalid", d_valid_o, 1);
    chk("bp_get_data[31:0]", d_data_o[31:0], 64'h55667788);
    nxt;

    // Illegal opcode, then misaligned Get
    req(3'd2, 3'd3, 2'd1, 64'h0, 8'hFF, 64'h1);
    @(negedge clk); chk("ill_op_req", sram_req_o, 0);
    nxt; a_valid_i = 1'b0;
    @(negedge clk);
    chk("ill_op_dvalid", d_valid_o, 1); chk("ill_op_den", d_denied_o, 1);
    chk("ill_op_data", d_data_o, 0); chk("ill_op_dop", d_opcode_o, 0);
    nxt;
    req(3'd4, 3'd3, 2'd2, 64'h4, 8'hFF, 64'd0);
    @(negedge clk); chk("ill_al_req", sram_req_o, 0);
    nxt; a_valid_i = 1'b0;
    @(negedge clk);
    chk("ill_al_dvalid", d_valid_o, 1); chk("ill_al_den", d_denied_o, 1); chk("ill_al_dop", d_opcode_o, 1);
    nxt;

    // Back-to-back Gets with a_valid held
    req(3'd4, 3'd3, 2'd0, 64'h10, 8'hFF, 64'd0);
    @(negedge clk); chk("b2b_req0", sram_req_o, 1);
    nxt;
    req(3'd4, 3'd3, 2'd1, 64'h18, 8'hFF, 64'd0);
    @(negedge clk); chk("b2b_n1_req", sram_req_o, 0); chk("b2b_n1_dvalid", d_valid_o, 0);
    nxt;
    @(negedge clk); chk("b2b_n2_dvalid", d_valid_o, 1); chk("b2b_n2_src", d_source_o, 0);
    nxt;
    @(negedge clk); chk("b2b_n3_req", sram_req_o, 1); chk("b2b_n3_addr", sram_addr_o, 3);
    nxt; a_valid_i = 1'b0;
    @(negedge clk); chk("b2b_n4_dvalid", d_valid_o, 0);
    nxt;
    @(negedge clk); chk("b2b_n5_dvalid", d_valid_o, 1); chk("b2b_n5_src", d_source_o, 1);
    nxt;

    // Reset pulse during RDWAIT
    req(3'd4, 3'd3, 2'd3, 64'h10, 8'hFF, 64'd0);
    @(negedge clk); chk("rs_req", sram_req_o, 1);
    nxt; rst_ni = 1'b0; a_valid_i = 1'b0;
    repeat (2) begin
      @(negedge clk); chk("rs_low_dvalid", d_valid_o, 0); chk("rs_low_aready", a_ready_o, 1);
      nxt;
    end
    rst_ni = 1'b1;
    @(negedge clk); chk("rs_rel_aready", a_ready_o, 1); chk("rs_rel_dvalid", d_valid_o, 0);
    repeat (3) begin
      nxt;
      @(negedge clk); chk("rs_after_dvalid", d_valid_o, 0);
    end
    nxt;

    // Randomized traffic; a request is held until accepted
    acc = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!a_valid_i || acc) begin
        if ($urandom_range(0, 2) != 0) rand_req();
        else a_valid_i = 1'b0;
      end
      d_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = a_valid_i && a_ready_o;
      nxt;
    end
    a_valid_i = 1'b0; d_ready_i = 1'b1;
    repeat (5) nxt;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
